// File: rtl/single_layer_perceptron.sv
// Single-layer perceptron: IN data inputs plus bias, STEP activation and
// perceptron-rule training applied on every clock edge while t_en is high.
// Ports:
//   clk     - rising-edge clock
//   reset_  - asynchronous reset, active-high; clears every weight
//   in      - input vector, IN elements in I_CONF format
//   out     - combinational activation output (ONE or ZERO, O_CONF format)
//   train   - training target, O_CONF format
//   rate    - learning rate, R_CONF format (fixed at 1 when R_CONF is INT)
//   t_en    - train enable
package slp_pkg;
  typedef enum logic [1:0] {FXP = 2'd0, INT = 2'd1, BOOL = 2'd2} dtype_t;
  typedef enum logic [1:0] {STEP = 2'd0, SIGMOID = 2'd1, RELU = 2'd2} actf_t;

  // Numeric format descriptor: value = field * 2^-frac, signed if sign set.
  typedef struct packed {
    dtype_t     dtype;
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;
endpackage

module single_layer_perceptron
  import slp_pkg::*;
#(
  parameter int unsigned IN     = 4,
  parameter dconf_t      I_CONF = '{dtype: FXP, sign: 1'b0, prec: 8'd4, frac: 8'd3},
  parameter dconf_t      R_CONF = '{dtype: FXP, sign: 1'b0, prec: 8'd4, frac: 8'd3},
  parameter dconf_t      W_CONF = '{dtype: FXP, sign: 1'b1, prec: 8'd5, frac: 8'd3},
  parameter dconf_t      O_CONF = '{dtype: FXP, sign: 1'b1, prec: 8'd5, frac: 8'd3},
  parameter actf_t       ACT    = STEP
) (
  input  logic                               clk,
  input  logic                               reset_,
  input  logic [IN-1:0][I_CONF.prec-1:0]     in,
  output logic [O_CONF.prec-1:0]             out,
  input  logic [O_CONF.prec-1:0]             train,
  input  logic [R_CONF.prec-1:0]             rate,
  input  logic                               t_en
);

  localparam int unsigned I_PREC = 32'(I_CONF.prec);
  localparam int unsigned R_PREC = 32'(R_CONF.prec);
  localparam int unsigned W_PREC = 32'(W_CONF.prec);
  localparam int unsigned O_PREC = 32'(O_CONF.prec);
  localparam int unsigned I_FRAC = (I_CONF.dtype == FXP) ? 32'(I_CONF.frac) : 32'd0;
  localparam int unsigned R_FRAC = (R_CONF.dtype == FXP) ? 32'(R_CONF.frac) : 32'd0;
  localparam int unsigned W_FRAC = (W_CONF.dtype == FXP) ? 32'(W_CONF.frac) : 32'd0;
  localparam int unsigned O_FRAC = (O_CONF.dtype == FXP) ? 32'(O_CONF.frac) : 32'd0;
  localparam bit          I_SIGNED = I_CONF.sign;
  localparam bit          O_SIGNED = O_CONF.sign;
  localparam bit          R_INT    = (R_CONF.dtype == INT);

  localparam int unsigned WEIGHT = IN + 1;
  localparam int unsigned X_W    = I_PREC + 1;
  localparam int unsigned ACC_W  = W_PREC + I_PREC + $clog2(IN + 1) + 1;
  localparam int unsigned P_W    = R_PREC + O_PREC + I_PREC + 3;
  localparam int unsigned S_W    = ((P_W > W_PREC) ? P_W : W_PREC) + 1;
  // Scale of rate*err*x relative to the weight scale.
  localparam int          SH     = int'(R_FRAC + O_FRAC + I_FRAC) - int'(W_FRAC);
  localparam int unsigned SH_R   = (SH > 0) ? 32'(SH) : 32'd0;
  localparam int unsigned SH_L   = (SH < 0) ? 32'(-SH) : 32'd0;

  localparam logic [O_PREC-1:0]      ONE   = O_PREC'(1) << O_FRAC;
  localparam logic signed [S_W-1:0]  W_MAX = S_W'((2 ** (W_PREC - 1)) - 1);
  localparam logic signed [S_W-1:0]  W_MIN = ~W_MAX;

  if (ACT != STEP) begin : g_act_check
    $error("single_layer_perceptron: only the STEP activation is supported");
  end

  logic [WEIGHT-1:0][W_PREC-1:0] w;
  logic [WEIGHT-1:0][W_PREC-1:0] w_next;
  logic signed [X_W-1:0]         x_ext [WEIGHT];
  logic signed [ACC_W-1:0]       acc;
  logic signed [O_PREC:0]        train_ext;
  logic signed [O_PREC:0]        out_ext;
  logic signed [O_PREC:0]        err;
  logic signed [R_PREC:0]        rate_ext;
  logic signed [P_W-1:0]         prod;
  logic signed [S_W-1:0]         upd;

  // Extend inputs to a common signed width; the bias input is a constant 1.0.
  always_comb begin
    for (int unsigned i = 0; i < IN; i++) begin
      if (I_SIGNED) x_ext[i] = X_W'($signed(in[i]));
      else          x_ext[i] = $signed({1'b0, in[i]});
    end
    x_ext[IN] = X_W'(1) << I_FRAC;
  end

  // Exact weighted sum and STEP activation; a zero sum maps to ZERO.
  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < WEIGHT; i++) begin
      acc = acc + ACC_W'($signed(w[i])) * ACC_W'(x_ext[i]);
    end
    out = (!acc[ACC_W-1] && (acc != '0)) ? ONE : '0;
  end

  // Perceptron rule: w <- sat(w + floor(rate * (train - out) * x)).
  always_comb begin
    if (O_SIGNED) train_ext = $signed({train[O_PREC-1], train});
    else          train_ext = $signed({1'b0, train});
    out_ext  = $signed({1'b0, out});
    err      = train_ext - out_ext;
    rate_ext = R_INT ? (R_PREC + 1)'(1) : $signed({1'b0, rate});
    w_next   = w;
    prod     = '0;
    upd      = '0;
    for (int unsigned i = 0; i < WEIGHT; i++) begin
      prod = P_W'(rate_ext) * P_W'(err) * P_W'(x_ext[i]);
      upd  = S_W'((prod >>> SH_R) <<< SH_L) + S_W'($signed(w[i]));
      if (upd > W_MAX)      w_next[i] = W_MAX[W_PREC-1:0];
      else if (upd < W_MIN) w_next[i] = W_MIN[W_PREC-1:0];
      else                  w_next[i] = upd[W_PREC-1:0];
    end
  end

  // Weight store; reset wins over a same-cycle update.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_)    w <= '0;
    else if (t_en) w <= w_next;
  end

endmodule

// File: tb/tb_single_layer_perceptron.sv
// Bench for single_layer_perceptron with default FXP parameters (IN = 4).
// A real-valued perceptron model tracks the weights and output.
module tb_single_layer_perceptron;

  logic                 clk = 1'b0;
  logic                 reset_;
  logic [3:0][3:0]      in;
  logic [4:0]           out;
  logic [4:0]           train;
  logic [3:0]           rate;
  logic                 t_en;

  int  n_cmp = 0;
  int  n_bad = 0;
  real mw [5];

  single_layer_perceptron dut (
    .clk    (clk),
    .reset_ (reset_),
    .in     (in),
    .out    (out),
    .train  (train),
    .rate   (rate),
    .t_en   (t_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model output: 1.0 (code 8) when bias + sum(w*x) > 0, in real arithmetic.
  function automatic int model_out();
    real s;
    s = mw[4];
    for (int i = 0; i < 4; i++) s += mw[i] * (real'(in[i]) / 8.0);
    return (s > 0.0) ? 8 : 0;
  endfunction

  // Model update: delta = rate*err*x floored to 1/8, weight clamped to [-2, 1.875].
  task automatic model_train(input int o_pre);
    real e, x, d, v;
    e = (real'($signed(train)) - real'(o_pre)) / 8.0;
    for (int i = 0; i < 5; i++) begin
      x = (i == 4) ? 1.0 : real'(in[i]) / 8.0;
      d = $floor((real'(rate) / 8.0) * e * x * 8.0) / 8.0;
      v = mw[i] + d;
      if (v > 1.875) v = 1.875;
      if (v < -2.0)  v = -2.0;
      mw[i] = v;
    end
  endtask

  task automatic check_model_w(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_w%0d", tag, i), int'($signed(dut.w[i])), $rtoi(mw[i] * 8.0));
  endtask

  task automatic check_w(input string tag, input int e_in, input int e_bias);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_w%0d", tag, i), int'($signed(dut.w[i])), e_in);
    check($sformatf("%s_bias", tag), int'($signed(dut.w[4])), e_bias);
  endtask

  // One cycle: drive at negedge, check pre-edge out, clock, check weights and new out.
  task automatic step(input logic [3:0][3:0] iv, input logic [4:0] tg,
                      input logic [3:0] rt, input logic te);
    int o_pre;
    @(negedge clk);
    in = iv; train = tg; rate = rt; t_en = te;
    #1;
    o_pre = model_out();
    check("out_pre", int'(out), o_pre);
    if (te) model_train(o_pre);
    @(posedge clk);
    #1;
    check_model_w("step");
    check("out_post", int'(out), model_out());
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ = 1'b1; t_en = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) mw[i] = 0.0;
    check_w("rst", 0, 0);
    @(negedge clk);
    reset_ = 1'b0;
  endtask

  initial begin
    logic [3:0][3:0] iv;
    logic [4:0]      tg;
    int              perm [16];
    int              j, tmp;

    reset_ = 1'b1;
    in = {4{4'b1000}}; train = '0; rate = '0; t_en = 1'b0;
    for (int i = 0; i < 5; i++) mw[i] = 0.0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out", int'(out), 0);
    check_w("rst", 0, 0);
    @(negedge clk);
    reset_ = 1'b0;
    #1;
    check("rst_rel_out", int'(out), 0);

    // Single positive update
    step({4{4'd8}}, 5'd8, 4'd1, 1'b1);
    check_w("pos", 1, 1);
    check("pos_out", int'(out), 8);

    // Negative update back to zero, then hold with t_en low
    step({4{4'd8}}, 5'd0, 4'd1, 1'b1);
    check_w("neg", 0, 0);
    check("neg_out", int'(out), 0);
    repeat (5) step({4{4'd8}}, 5'd8, 4'd1, 1'b0);
    check_w("hold", 0, 0);

    // Zero input trains only the bias
    step('0, 5'd8, 4'd1, 1'b1);
    check_w("zin", 0, 1);
    check("zin_out", int'(out), 8);

    // Reset held across an enabled training edge wins
    @(negedge clk);
    in = {4{4'd8}}; train = 5'd8; rate = 4'd1; t_en = 1'b1; reset_ = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) mw[i] = 0.0;
    check_w("rstpri", 0, 0);
    @(negedge clk);
    reset_ = 1'b0; t_en = 1'b0;

    // Saturation: 15/8 * 1 * 15/8 = 3.515625 clamps to 1.875
    step({4'd0, 4'd0, 4'd0, 4'd15}, 5'd8, 4'd15, 1'b1);
    check("sat_w0", int'($signed(dut.w[0])), 15);
    check("sat_w1", int'($signed(dut.w[1])), 0);
    check("sat_bias", int'($signed(dut.w[4])), 15);

    // AND learning
    do_reset();
    for (int k = 0; k < 16; k++) perm[k] = k;
    for (int ep = 0; ep < 100; ep++) begin
      for (int k = 15; k > 0; k--) begin
        j = int'($urandom_range(0, k));
        tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
      for (int k = 0; k < 16; k++) begin
        for (int i = 0; i < 4; i++) iv[i] = perm[k][i] ? 4'd8 : 4'd0;
        tg = (perm[k] == 15) ? 5'd8 : 5'd0;
        step(iv, tg, 4'd1, 1'b1);
      end
    end
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 4; i++) iv[i] = p[i] ? 4'd8 : 4'd0;
      step(iv, 5'd0, 4'd1, 1'b0);
      check($sformatf("and_p%0d", p), int'(out), (p == 15) ? 8 : 0);
    end

    // Random training against the model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) iv[i] = 4'($urandom_range(0, 15));
      tg = ($urandom_range(0, 1) == 1) ? 5'd8 : 5'd0;
      step(iv, tg, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
